// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory handshake FSM with timeout, priority-encoded
// pipeline enables, and saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  input  logic             hazard_i,
  input  logic             branch_i,
  output logic             mem_req_o,
  output logic             mem_stall_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             stage_en_o,
  output logic             mem_wb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_o   = 1'b0;
    mem_stall_o = 1'b0;
    err_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_req_o   = mem_access_i;
        mem_stall_o = mem_access_i & ~mem_ack_i;
        if (mem_access_i && !mem_ack_i) begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        mem_req_o   = 1'b1;
        mem_stall_o = ~mem_ack_i;
        // Ack beats timeout when both land in the same cycle.
        if (mem_ack_i) begin
          state_d = StIdle;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StErr: begin
        mem_stall_o = 1'b1;
        err_o       = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b1;
    if_id_write_o   = 1'b1;
    stage_en_o      = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (mem_stall_o) begin
      pc_write_o      = 1'b0;
      if_id_write_o   = 1'b0;
      stage_en_o      = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (hazard_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (branch_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (mem_stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (if_id_flush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with TIMEOUT=8.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, mem_access, mem_ack, hazard, branch;
  logic        mem_req, mem_stall, pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic        stage_en, mem_wb_bubble, err;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .TIMEOUT(8),
    .CNT_W  (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_access_i   (mem_access),
    .mem_ack_i      (mem_ack),
    .hazard_i       (hazard),
    .branch_i       (branch),
    .mem_req_o      (mem_req),
    .mem_stall_o    (mem_stall),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .stage_en_o     (stage_en),
    .mem_wb_bubble_o(mem_wb_bubble),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance one cycle; new inputs are applied 1ns after the edge, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic acc, input logic ack, input logic haz, input logic br);
    mem_access = acc;
    mem_ack    = ack;
    hazard     = haz;
    branch     = br;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Post-reset idle state
    check("rst_pc_write", pc_write, 1);
    check("rst_if_id_write", if_id_write, 1);
    check("rst_stage_en", stage_en, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_flushes", {if_id_flush, id_ex_flush, mem_wb_bubble}, 0);
    check("rst_err", err, 0);
    check("rst_cnts", {stall_cnt, flush_cnt}, 0);

    // Zero-stall completion
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("zs_req", mem_req, 1);
    check("zs_stall", mem_stall, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("zs_idle_req", mem_req, 0);
    check("zs_stall_cnt", stall_cnt, 0);

    // Ack after 4 stall cycles
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("w4_stall%0d", c), mem_stall, 1);
      check($sformatf("w4_bubble%0d", c), mem_wb_bubble, 1);
      check($sformatf("w4_en%0d", c), {pc_write, if_id_write, stage_en}, 0);
      check($sformatf("w4_req%0d", c), mem_req, 1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("w4_ack_stall", mem_stall, 0);
    check("w4_ack_en", {pc_write, if_id_write, stage_en}, 3'b111);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("w4_stall_cnt", stall_cnt, 4);
    check("w4_idle_stall", mem_stall, 0);

    // Hazard outranks branch
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("hb_en", {pc_write, if_id_write, stage_en}, 3'b001);
    check("hb_flush", {if_id_flush, id_ex_flush}, 2'b01);
    tick();
    check("hb_flush_cnt", flush_cnt, 0);

    // Branch only
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("br_flush", {if_id_flush, id_ex_flush}, 2'b10);
    check("br_en", {pc_write, if_id_write, stage_en}, 3'b111);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("br_flush_cnt", flush_cnt, 1);

    // Stall overrides hazard/branch, then time out after 8 WAIT cycles
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("st_haz_ignored", {if_id_flush, id_ex_flush, pc_write}, 0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("to_wait%0d_err", c), err, 0);
      tick();
    end
    check("to_err", err, 1);
    check("to_req", mem_req, 0);
    check("to_stall", mem_stall, 1);
    check("to_stall_cnt", stall_cnt, 13);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("to_err_sticky_ack", err, 1);
    tick();
    check("to_err_held", err, 1);

    // Reset out of ERR
    do_reset();
    check("rerr_err", err, 0);
    check("rerr_cnts", {stall_cnt, flush_cnt}, 0);
    check("rerr_req", mem_req, 0);

    // Ack on 8th WAIT cycle wins over timeout
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 1; c <= 7; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("a8_stall", mem_stall, 0);
    check("a8_err", err, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("a8_idle_req", mem_req, 0);
    check("a8_err_after", err, 0);
    check("a8_stall_cnt", stall_cnt, 8);

    // Reset during WAIT cycle 2
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();
    check("rw_req", mem_req, 0);
    check("rw_stall", mem_stall, 0);
    check("rw_cnt", stall_cnt, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("rw_idle_req", mem_req, 1);
    check("rw_idle_stall", mem_stall, 0);

    // Stall counter saturation (held via ERR)
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 65540; c++) tick();
    check("sat_err", err, 1);
    check("sat_cnt", stall_cnt, 16'hffff);
    tick();
    tick();
    check("sat_hold", stall_cnt, 16'hffff);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
